sub_checker_r4_n6: RTL and testbench
====================================

SUB_CHECKER_R4_N6 -- requirements
Module: sub_checker_r4_n6

Interface
REQ-001 Parameter NUM_TESTS, default 10, number of test vectors walked (indices 0..NUM_TESTS-1); legal range 1..16.
REQ-002 Parameter SETTLE_CYCLES, default 2, cycles a vector is held before sampling; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse that starts a run.
REQ-006 z_exp  in  21  expected result: 7 radix-4 signed digits, 3-bit two's complement each, digit 6 in [20:18].
REQ-007 z_dut  in  21  subtractor-under-test result, same format as z_exp.
REQ-008 test_select  out  4  vector index driven to the vector-table stage.
REQ-009 busy  out  1  run in progress.
REQ-010 done  out  1  run complete; held until the next accepted start.
REQ-011 pass  out  1  done and no test failed.
REQ-012 err_count  out  5  number of failed tests in the current or last run.
REQ-013 fail_mask  out  16  bit i set when test i failed.
REQ-014 first_fail  out  4  index of the lowest failed test; 0 when there is none.
REQ-015 illegal_digit  out  1  sticky; set when any sampled digit equals 3'b100.

Function
REQ-016 The FSM SHALL have the states IDLE, APPLY, CHECK and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL enter APPLY, set index to 0, load the settle counter with SETTLE_CYCLES, and clear err_count, fail_mask, first_fail and illegal_digit.
REQ-018 In APPLY the FSM SHALL decrement the settle counter once per cycle and move to CHECK on the cycle the counter reaches 1.
REQ-019 CHECK SHALL last exactly one cycle; on it the FSM SHALL compare the numeric values of z_exp and z_dut.
REQ-020 The numeric value of a digit vector SHALL be sum(d_i*4^i), i=0..6, with each d_i sign-extended; the result is held as 16-bit signed (range ±16383).
REQ-021 A test SHALL fail when the two values differ or when any digit of z_dut is 3'b100.
REQ-022 Digit-encoding differences between z_exp and z_dut that give an equal value SHALL NOT count as a failure.
REQ-023 On a failure the block SHALL increment err_count, set fail_mask[index], and load first_fail only if this is the first failure of the run.
REQ-024 From CHECK, when index==NUM_TESTS-1 the FSM SHALL go to DONE; otherwise it SHALL increment index, reload the settle counter and return to APPLY.
REQ-025 test_select SHALL equal index in APPLY and CHECK, hold its last value in DONE, and be 0 in IDLE.
REQ-026 busy SHALL be 1 exactly in APPLY and CHECK.
REQ-027 done SHALL be 1 exactly in DONE; pass SHALL equal done AND (err_count==0).
REQ-028 If start is sampled at edge k, done SHALL rise at edge k + NUM_TESTS*(SETTLE_CYCLES+1); with the defaults this is 30 cycles.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 A start in DONE SHALL restart the run; the same edge clears all results.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, index 0, test_select 0, busy 0, done 0, pass 0, err_count 0, fail_mask 0, first_fail 0, illegal_digit 0.
REQ-032 Reset during a run SHALL discard all partial results; no output keeps a pre-reset value.

Structure
REQ-033 The shared package SHALL hold the digit width (3), the radix (4), the digit count (7), the FSM state enumeration and the illegal-digit code 3'b100.
REQ-034 The digit-to-integer conversion SHALL be one combinational sub-module, rsd_to_int_r4, instantiated once for z_exp and once for z_dut.
REQ-035 The vector-table stage connects its x and y outputs straight to the device under test; they SHALL NOT pass through this block.

Verification
REQ-036 Reset: assert rst_n=0 mid-run at index 5 -> all outputs are 0 within that cycle; a later start runs to pass=1.
REQ-037 Ideal DUT: z_dut tied to z_exp, one start -> done at +30 cycles, pass=1, err_count=0, fail_mask=0.
REQ-038 Redundant equivalence: on test 3, z_dut digits {0,0,0,0,0,1,-3} against z_exp value 1 -> no failure recorded.
REQ-039 Single fault: z_dut = z_exp with digit 0 incremented, on test 4 only -> err_count=1, fail_mask=0x0010, first_fail=4, pass=0.
REQ-040 Illegal digit: 3'b100 in z_dut digit 2 on test 7 -> illegal_digit=1, fail_mask bit 7 set, flag sticky through DONE.
REQ-041 Busy start: extra start pulses at cycles 5 and 12 of a run -> run timing unchanged; done still at +30.

Source files
------------

// File: rtl/sub_checker_r4_n6_pkg.sv
// Shared definitions for the radix-4 signed-digit subtractor checker.
package sub_checker_r4_n6_pkg;

    localparam int unsigned DIGIT_W     = 3;
    localparam int unsigned RADIX       = 4;
    localparam int unsigned NUM_DIGITS  = 7;
    localparam int unsigned RADIX_SHIFT = $clog2(RADIX);
    localparam int unsigned Z_W         = DIGIT_W * NUM_DIGITS;
    localparam int unsigned VALUE_W     = 16;
    localparam int unsigned INDEX_W     = 4;
    localparam int unsigned SETTLE_W    = 4;
    localparam int unsigned ERR_W       = 5;
    localparam int unsigned MASK_W      = 16;

    localparam logic [DIGIT_W-1:0] ILLEGAL_DIGIT = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when any digit of the vector carries the reserved -4 code.
    function automatic logic has_illegal_digit(input logic [Z_W-1:0] z);
        logic found;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (z[i*DIGIT_W +: DIGIT_W] == ILLEGAL_DIGIT) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/sub_checker_r4_n6_rsd_to_int_r4.sv
// Combinational conversion of a radix-4 signed-digit vector to its integer value.
module rsd_to_int_r4
    import sub_checker_r4_n6_pkg::*;
(
    input  logic [Z_W-1:0]            z,
    output logic signed [VALUE_W-1:0] value_c
);

    logic signed [VALUE_W-1:0] acc;
    logic        [DIGIT_W-1:0] d;

    // Each digit is sign-extended and weighted by 4^i.
    always_comb begin
        acc = '0;
        d   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            d   = z[i*DIGIT_W +: DIGIT_W];
            acc = acc + ($signed({{(VALUE_W-DIGIT_W){d[DIGIT_W-1]}}, d}) <<< (i * RADIX_SHIFT));
        end
        value_c = acc;
    end

endmodule

// File: rtl/sub_checker_r4_n6.sv
// Walks a vector table, compares subtractor results by numeric value and
// accumulates pass/fail statistics for the run.
module sub_checker_r4_n6
    import sub_checker_r4_n6_pkg::*;
#(
    parameter int unsigned NUM_TESTS     = 10,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [Z_W-1:0]      z_exp,
    input  logic [Z_W-1:0]      z_dut,
    output logic [INDEX_W-1:0]  test_select,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [MASK_W-1:0]   fail_mask,
    output logic [INDEX_W-1:0]  first_fail,
    output logic                illegal_digit
);

    localparam logic [INDEX_W-1:0]  LAST_INDEX  = INDEX_W'(NUM_TESTS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    state_e                state_q, state_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [INDEX_W-1:0]    index_d;
    logic [ERR_W-1:0]      err_d;
    logic [MASK_W-1:0]     mask_d;
    logic [INDEX_W-1:0]    first_d;
    logic                  illegal_d;

    logic signed [VALUE_W-1:0] val_exp_c, val_dut_c;
    logic                      dut_illegal_c, exp_illegal_c, fail_c;

    rsd_to_int_r4 u_conv_exp (.z(z_exp), .value_c(val_exp_c));
    rsd_to_int_r4 u_conv_dut (.z(z_dut), .value_c(val_dut_c));

    assign dut_illegal_c = has_illegal_digit(z_dut);
    assign exp_illegal_c = has_illegal_digit(z_exp);
    assign fail_c        = (val_exp_c != val_dut_c) || dut_illegal_c;

    // Next-state and result update.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        index_d   = test_select;
        err_d     = err_count;
        mask_d    = fail_mask;
        first_d   = first_fail;
        illegal_d = illegal_digit;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_APPLY;
                    index_d   = '0;
                    settle_d  = SETTLE_LOAD;
                    err_d     = '0;
                    mask_d    = '0;
                    first_d   = '0;
                    illegal_d = 1'b0;
                end
            end
            ST_APPLY: begin
                settle_d = settle_q - SETTLE_W'(1);
                if (settle_q == SETTLE_W'(1)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (dut_illegal_c || exp_illegal_c) begin
                    illegal_d = 1'b1;
                end
                if (fail_c) begin
                    err_d               = err_count + ERR_W'(1);
                    mask_d[test_select] = 1'b1;
                    if (err_count == '0) begin
                        first_d = test_select;
                    end
                end
                if (test_select == LAST_INDEX) begin
                    state_d = ST_DONE;
                end else begin
                    index_d  = test_select + INDEX_W'(1);
                    settle_d = SETTLE_LOAD;
                    state_d  = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All state and outputs are registered; status flags decode the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            test_select   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            fail_mask     <= '0;
            first_fail    <= '0;
            illegal_digit <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            test_select   <= index_d;
            busy          <= (state_d == ST_APPLY) || (state_d == ST_CHECK);
            done          <= (state_d == ST_DONE);
            pass          <= (state_d == ST_DONE) && (err_d == '0);
            err_count     <= err_d;
            fail_mask     <= mask_d;
            first_fail    <= first_d;
            illegal_digit <= illegal_d;
        end
    end

endmodule

// File: tb/tb_sub_checker_r4_n6.sv
// Directed bench for sub_checker_r4_n6 with a behavioural vector table and DUT stand-in.
module tb_sub_checker_r4_n6;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [20:0] z_exp;
    logic [20:0] z_dut;
    logic [3:0]  test_select;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [15:0] fail_mask;
    logic [3:0]  first_fail;
    logic        illegal_digit;

    int n_cmp  = 0;
    int n_mism = 0;
    int mode   = 0;

    sub_checker_r4_n6 #(.NUM_TESTS(10), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .z_exp(z_exp), .z_dut(z_dut),
        .test_select(test_select), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_mask(fail_mask), .first_fail(first_fail),
        .illegal_digit(illegal_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-result table, digits listed d6..d0.
    function automatic logic [20:0] exp_vec(input logic [3:0] idx);
        case (idx)
            4'd0: return 21'h0;
            4'd1: return {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
            4'd2: return {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd7};
            4'd3: return 21'h1;
            4'd4: return {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd2};
            4'd5: return {3'd3, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
            4'd6: return {3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
            4'd7: return {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
            4'd8: return {3'd7, 3'd6, 3'd5, 3'd0, 3'd3, 3'd2, 3'd1};
            4'd9: return {3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
            default: return 21'h0;
        endcase
    endfunction

    // Vector table plus subtractor stand-in; mode selects the injected behaviour.
    always_comb begin
        z_exp = exp_vec(test_select);
        z_dut = z_exp;
        case (mode)
            1: if (test_select == 4'd3) z_dut = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'b101};
            2: if (test_select == 4'd4) z_dut[2:0] = z_exp[2:0] + 3'd1;
            3: if (test_select == 4'd7) z_dut[8:6] = 3'b100;
            4: if (test_select == 4'd2 || test_select == 4'd8) z_dut[2:0] = z_exp[2:0] + 3'd1;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mism++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One run: start sampled at edge k, done expected exactly at edge k+30.
    task automatic do_run(input bit extra_starts);
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            start = extra_starts && (c == 5 || c == 12);
            if (c == 1) begin
                check("run_busy_start", 32'(busy), 32'd1);
                check("run_cleared_err", 32'(err_count), 32'd0);
                check("run_cleared_mask", 32'(fail_mask), 32'd0);
                check("run_cleared_ill", 32'(illegal_digit), 32'd0);
                check("run_done_low", 32'(done), 32'd0);
            end
            if (c == 30) begin
                check("done_not_early", 32'(done), 32'd0);
                check("busy_last_check", 32'(busy), 32'd1);
            end
        end
        check("done_at_30", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("test_select_done", 32'(test_select), 32'd9);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_mask", 32'(fail_mask), 32'd0);
        check("rst_tsel", 32'(test_select), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);

        // Ideal subtractor
        mode = 0;
        do_run(1'b0);
        check("ideal_pass", 32'(pass), 32'd1);
        check("ideal_err", 32'(err_count), 32'd0);
        check("ideal_mask", 32'(fail_mask), 32'd0);
        check("ideal_first", 32'(first_fail), 32'd0);

        // Redundant encoding with equal value
        mode = 1;
        do_run(1'b0);
        check("redund_pass", 32'(pass), 32'd1);
        check("redund_err", 32'(err_count), 32'd0);
        check("redund_mask", 32'(fail_mask), 32'd0);

        // Single fault on test 4
        mode = 2;
        do_run(1'b0);
        check("fault_err", 32'(err_count), 32'd1);
        check("fault_mask", 32'(fail_mask), 32'h0010);
        check("fault_first", 32'(first_fail), 32'd4);
        check("fault_pass", 32'(pass), 32'd0);
        check("fault_ill", 32'(illegal_digit), 32'd0);

        // Illegal digit on test 7, sticky through DONE
        mode = 3;
        do_run(1'b0);
        check("ill_flag", 32'(illegal_digit), 32'd1);
        check("ill_mask", 32'(fail_mask), 32'h0080);
        check("ill_first", 32'(first_fail), 32'd7);
        repeat (5) @(negedge clk);
        check("ill_sticky", 32'(illegal_digit), 32'd1);
        check("ill_done_held", 32'(done), 32'd1);

        // Two faults: first_fail keeps the lowest index
        mode = 4;
        do_run(1'b0);
        check("two_err", 32'(err_count), 32'd2);
        check("two_mask", 32'(fail_mask), 32'h0104);
        check("two_first", 32'(first_fail), 32'd2);

        // Start pulses while busy are ignored
        mode = 0;
        do_run(1'b1);
        check("busy_start_pass", 32'(pass), 32'd1);

        // Reset mid-run at index 5
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (test_select == 4'd5) break;
            @(negedge clk);
        end
        check("reach_idx5", 32'(test_select), 32'd5);
        check("pre_rst_err", 32'(err_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tsel", 32'(test_select), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_pass", 32'(pass), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        check("mid_rst_mask", 32'(fail_mask), 32'd0);
        check("mid_rst_first", 32'(first_fail), 32'd0);
        check("mid_rst_ill", 32'(illegal_digit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        do_run(1'b0);
        check("post_rst_pass", 32'(pass), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
